// File: rtl/pc_stack_if.sv
// Fetch-side bus bundle for pc_stack: control strobes, jump target and PC/stack status.
// With PC_STACK_REL_BRANCH_EN defined, the bundle also carries the relative-branch strobe.
interface pc_stack_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             inc;
  logic             write;
  logic             read;
  logic             call;
  logic             ret;
`ifdef PC_STACK_REL_BRANCH_EN
  logic             branch;
`endif
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp;
  logic             stack_full;
  logic             stack_empty;
  logic             err;

  // Controls are level-sampled on each rising clk edge; there is no
  // valid/ready handshake, a strobe high at an edge is always accepted
  // unless a higher-priority strobe wins that edge.
  modport master (
    output inc, write, read, call, ret,
`ifdef PC_STACK_REL_BRANCH_EN
    output branch,
`endif
    output din,
    input  dout, pc, sp, stack_full, stack_empty, err
  );

  modport slave (
    input  inc, write, read, call, ret,
`ifdef PC_STACK_REL_BRANCH_EN
    input  branch,
`endif
    input  din,
    output dout, pc, sp, stack_full, stack_empty, err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack and sticky misuse flag.
// Optional relative branch (pc += signed din) enabled by PC_STACK_REL_BRANCH_EN.
module pc_stack #(
  parameter int               WIDTH        = 9,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_stack_if.slave bus
);
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_WRITE,
    ACT_CALL,
    ACT_RET,
    ACT_BRANCH,
    ACT_INC
  } action_t;

  logic [WIDTH-1:0] r_pc;
  logic [SPW-1:0]   r_sp;
  logic             r_err;
  logic [WIDTH-1:0] r_stack [DEPTH];

  action_t          w_act;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [SPW-1:0]   w_sp_nxt;
  logic             w_err_nxt;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_pc_inc;
  logic [IDXW-1:0]  w_push_idx;
  logic [IDXW-1:0]  w_top_idx;

  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign w_push_idx = IDXW'(r_sp);
  assign w_top_idx  = IDXW'(r_sp - SPW'(1));

  // Fixed priority: exactly one action per edge, losers have no side effects.
  always_comb begin
    w_act = ACT_HOLD;
    if (bus.write)       w_act = ACT_WRITE;
    else if (bus.call)   w_act = ACT_CALL;
    else if (bus.ret)    w_act = ACT_RET;
`ifdef PC_STACK_REL_BRANCH_EN
    else if (bus.branch) w_act = ACT_BRANCH;
`endif
    else if (bus.inc)    w_act = ACT_INC;
  end

  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    case (w_act)
      ACT_WRITE: w_pc_nxt = bus.din;
      ACT_CALL: begin
        w_pc_nxt = bus.din;
        if (w_full) begin
          w_err_nxt = 1'b1;
        end else begin
          w_push   = 1'b1;
          w_sp_nxt = r_sp + SPW'(1);
        end
      end
      ACT_RET: begin
        if (w_empty) begin
          w_err_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_stack[w_top_idx];
          w_sp_nxt = r_sp - SPW'(1);
        end
      end
`ifdef PC_STACK_REL_BRANCH_EN
      // Two's-complement add modulo 2^WIDTH needs no sign extension.
      ACT_BRANCH: w_pc_nxt = r_pc + bus.din;
`endif
      ACT_INC: w_pc_nxt = w_pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign bus.pc          = r_pc;
  assign bus.sp          = r_sp;
  assign bus.err         = r_err;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.dout        = bus.read ? r_pc : '0;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=9, DEPTH=4) with hand-computed expectations.
// Relative-branch vectors run only when PC_STACK_REL_BRANCH_EN is defined.
module tb_pc_stack;
  localparam int WIDTH = 9;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(9'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.write = 1'b0;
    bus.call  = 1'b0;
    bus.ret   = 1'b0;
    bus.inc   = 1'b0;
`ifdef PC_STACK_REL_BRANCH_EN
    bus.branch = 1'b0;
`endif
  endtask

  // Drive one edge worth of controls; returns #1 after the edge.
  task automatic do_op(input logic w, input logic c, input logic r, input logic i,
                       input logic [WIDTH-1:0] d);
    bus.write = w;
    bus.call  = c;
    bus.ret   = r;
    bus.inc   = i;
    bus.din   = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] pc,
                             input int sp, input logic err);
    check({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    check({tag, ".sp"}, 32'(bus.sp), 32'(sp));
    check({tag, ".err"}, 32'(bus.err), 32'(err));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    bus.read = 1'b0;
    bus.din  = '0;

    // reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 9'h000, 0, 1'b0);
    check("reset.empty", 32'(bus.stack_empty), 32'd1);
    check("reset.full", 32'(bus.stack_full), 32'd0);
    reset = 1'b0;

    // increment and read gating
    repeat (3) do_op(1'b0, 1'b0, 1'b0, 1'b1, 9'h000);
    check("inc3.pc", 32'(bus.pc), 32'h3);
    check("dout.read0", 32'(bus.dout), 32'h0);
    bus.read = 1'b1;
    #1;
    check("dout.read1", 32'(bus.dout), 32'h3);
    bus.read = 1'b0;

    // jump, wrap, write beats inc
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h1FF);
    check("jump.pc", 32'(bus.pc), 32'h1FF);
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 9'h000);
    check("wrap.pc", 32'(bus.pc), 32'h000);
    do_op(1'b1, 1'b0, 1'b0, 1'b1, 9'h00B);
    check("write_inc.pc", 32'(bus.pc), 32'h00B);

    // nested call / return
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h010);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h040);
    check_state("call1", 9'h040, 1, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h080);
    check_state("call2", 9'h080, 2, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("ret1", 9'h041, 1, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("ret2", 9'h011, 0, 1'b0);
    check("ret2.empty", 32'(bus.stack_empty), 32'd1);

    // overflow
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h100);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h020);  // pushes 0x101
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h030);  // pushes 0x021
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h040);  // pushes 0x031
    check("call3.full", 32'(bus.stack_full), 32'd0);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h050);  // pushes 0x041
    check_state("call4", 9'h050, 4, 1'b0);
    check("call4.full", 32'(bus.stack_full), 32'd1);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h055);
    check_state("ovf", 9'h055, 4, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("lifo1", 9'h041, 3, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("lifo2", 9'h031, 2, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("lifo3", 9'h021, 1, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("lifo4", 9'h101, 0, 1'b1);

    // asynchronous reset mid-cycle clears err
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h0AA);
    bus.read = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 9'h000, 0, 1'b0);
    check("async_rst.dout", 32'(bus.dout), 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.read = 1'b0;

    // underflow
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h022);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check_state("udf", 9'h022, 0, 1'b1);

    // call beats ret, then back-to-back ret
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 9'h060);
    check_state("call_ret", 9'h060, 1, 1'b1);
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 9'h000);
    check_state("ret_inc", 9'h023, 0, 1'b1);

    // return address wraps at all-ones
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h1FF);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 9'h005);
    check("wrapcall.pc", 32'(bus.pc), 32'h005);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    check("wrapret.pc", 32'(bus.pc), 32'h000);

`ifdef PC_STACK_REL_BRANCH_EN
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h010);
    bus.branch = 1'b1;
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 9'h1FC);
    check("branch_neg.pc", 32'(bus.pc), 32'h00C);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h1FE);
    bus.branch = 1'b1;
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 9'h005);
    check("branch_wrap.pc", 32'(bus.pc), 32'h003);
    bus.branch = 1'b1;
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 9'h077);
    check("write_branch.pc", 32'(bus.pc), 32'h077);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack. Successor to the 9-bit PC: width and stack depth are generic, and subroutine call/return is supported directly, with a sticky error flag for stack misuse. Sits in the fetch stage. It drives the instruction-memory address and the shared data bus (via `read`). It takes jump targets from the bus (via `din`).

## Interface
Parameters:
- `WIDTH`, 9, PC / address width in bits (≥2).
- `DEPTH`, 4, return-stack entries (≥1).
- `RESET_VECTOR`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inc`  in  1  advance PC by 1.
- `write`  in  1  load PC from `din` (jump).
- `read`  in  1  bus output enable for `dout`.
- `call`  in  1  push PC+1, load PC from `din`.
- `ret`  in  1  pop top of stack into PC.
- `din`  in  WIDTH  jump/call target.
- `dout`  out  WIDTH  `pc` when `read`=1, else all zeros.
- `pc`  out  WIDTH  current PC, always driven.
- `sp`  out  clog2(DEPTH+1)  number of valid stack entries.
- `stack_full`  out  1  `sp`==DEPTH.
- `stack_empty`  out  1  `sp`==0.
- `err`  out  1  sticky stack-misuse flag.

## Operation
- Reset (async, any time, including mid-operation):
  - `pc`=RESET_VECTOR, `sp`=0, `err`=0.
  - Stack contents are don't-care.
  - `dout`=0 unless `read`=1 (then RESET_VECTOR).
- Exactly one action per cycle, chosen by fixed priority `write` > `call` > `ret` > `branch` (macro only) > `inc` > hold. Lower-priority requests in the same cycle are ignored, with no side effects.
- `write`: `pc`←`din`. Stack untouched.
- `call`:
  - Not full: `stack[sp]`←`pc`+1 (mod 2^WIDTH), `sp`←`sp`+1, `pc`←`din`.
  - Full: `pc`←`din`, no push, `sp` unchanged, `err`←1.
- `ret`:
  - Not empty: `pc`←`stack[sp-1]`, `sp`←`sp`-1.
  - Empty: `pc` holds, `err`←1.
- `inc`: `pc`←`pc`+1. Wraps from all-ones to 0, no flag.
- `err` is cleared only by `reset`.
- `dout`, `stack_full` and `stack_empty` are combinational from registers. They do not depend on `call`, `ret`, `inc` or `write` in the current cycle.

## Timing
- Every action has 1-cycle latency. The new `pc`/`sp` is visible immediately after the rising edge where the request was sampled high.
- Controls are level-sampled each edge. Holding `inc` high for N edges advances `pc` by N.
- A `call` followed directly by `ret` on the next edge returns to the call address +1. There are no bubbles.
- `read` is combinational to `dout` (no register stage).
- `reset` asserts asynchronously. Release must be synchronous to `clk` (handled externally). The first action is taken on the first edge after release.

## Configuration
- Macro: `PC_STACK_REL_BRANCH_EN`.
- Defined:
  - Adds input `branch` (1 bit).
  - When `branch` wins priority: `pc`←`pc`+`din`, with `din` treated as two's-complement WIDTH bits, modulo 2^WIDTH. Stack untouched.
- Undefined: no `branch` port. Priority is `write` > `call` > `ret` > `inc`.

## Test plan
- Reset and increment (WIDTH=9):
  - Assert `reset` mid-cycle → `pc`=0, `sp`=0, `err`=0 immediately.
  - Release, `inc`=1 for 3 edges → `pc`=3.
  - `read`=0 → `dout`=0. `read`=1 → `dout`=3.
- Jump and wrap:
  - `write`=1, `din`=9'h1FF → `pc`=0x1FF.
  - Then `inc` → `pc`=0.
  - `write`+`inc` in the same cycle with `din`=0x0B → `pc`=0x0B.
- Nested call/return (DEPTH=4):
  - From `pc`=0x10, `call` to 0x40, then 0x80 → `sp`=2.
  - `ret` → `pc`=0x41, `ret` → `pc`=0x11, `stack_empty`=1, `err`=0.
- Overflow:
  - 4 calls → `stack_full`=1.
  - 5th `call` with `din`=0x55 → `pc`=0x55, `sp`=4, `err`=1.
  - 4 `ret`s return the original 4 addresses in LIFO order. `err` stays 1.
- Underflow and priority:
  - `ret` with `sp`=0 at `pc`=0x22 → `pc`=0x22, `err`=1.
  - `call`+`ret` in the same cycle → call only, `sp`+1.
- Macro on:
  - `pc`=0x010, `branch`=1, `din`=9'h1FC (−4) → `pc`=0x00C.
  - `pc`=0x1FE, `din`=5 → `pc`=0x003.
